// File: rtl/score_ssd_driver.sv
// Score-to-7-segment driver: sequential double-dabble binary->BCD plus an 8-digit scanner.
// Define SSD_LZB_EN to blank leading zeros on digits 1..4.
module score_ssd_driver #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] score,
   output logic [7:0]  An,
   output logic [6:0]  Cath,
   output logic        Dp,
   output logic        busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_LATCH = 2'd2;

   localparam int RC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

   logic [1:0]      state;
   logic [15:0]     shreg;
   logic [15:0]     cap_score;
   logic [15:0]     last_score;
   logic [19:0]     bcd;
   logic [19:0]     bcd_adj;
   logic [19:0]     disp_bcd;
   logic [3:0]      shcnt;
   logic            first;

   logic [RC_W-1:0] rc;
   logic [2:0]      idx;
   logic [3:0]      nib;
   logic            blank;
   logic            lit;
   logic [7:0]      an_nxt;
   logic [6:0]      cath_nxt;

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = 7'b1111111;
      endcase
   endfunction

   // Add-3 correction on every nibble before the shift keeps each digit in 0..9.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         first      <= 1'b1;
         last_score <= 16'd0;
         cap_score  <= 16'd0;
         shreg      <= 16'd0;
         bcd        <= 20'd0;
         shcnt      <= 4'd0;
         disp_bcd   <= 20'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (first || (score != last_score)) begin
                  shreg     <= score;
                  cap_score <= score;
                  bcd       <= 20'd0;
                  shcnt     <= 4'd0;
                  state     <= S_SHIFT;
                  busy      <= 1'b1;
               end
            end
            S_SHIFT: begin
               {bcd, shreg} <= {bcd_adj, shreg} << 1;
               shcnt        <= shcnt + 4'd1;
               if (shcnt == 4'd15)
                  state <= S_LATCH;
            end
            S_LATCH: begin
               disp_bcd   <= bcd;
               last_score <= cap_score;
               first      <= 1'b0;
               state      <= S_IDLE;
               busy       <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      nib = 4'd0;
      case (idx)
         3'd0:    nib = disp_bcd[3:0];
         3'd1:    nib = disp_bcd[7:4];
         3'd2:    nib = disp_bcd[11:8];
         3'd3:    nib = disp_bcd[15:12];
         3'd4:    nib = disp_bcd[19:16];
         default: nib = 4'd0;
      endcase
   end

`ifdef SSD_LZB_EN
   // A digit is blank when it and every more significant digit are zero.
   always_comb begin
      blank = 1'b0;
      case (idx)
         3'd1:    blank = (disp_bcd[19:4]  == 16'd0);
         3'd2:    blank = (disp_bcd[19:8]  == 12'd0);
         3'd3:    blank = (disp_bcd[19:12] == 8'd0);
         3'd4:    blank = (disp_bcd[19:16] == 4'd0);
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   assign lit      = (idx < 3'd5) && !blank;
   assign an_nxt   = lit ? ~(8'b1 << idx) : 8'hFF;
   assign cath_nxt = lit ? seg(nib) : 7'h7F;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rc   <= '0;
         idx  <= 3'd0;
         An   <= 8'hFF;
         Cath <= 7'h7F;
         Dp   <= 1'b1;
      end else begin
         if (rc == RC_LAST) begin
            rc  <= '0;
            idx <= idx + 3'd1;
         end else begin
            rc <= rc + 1'b1;
         end
         An   <= an_nxt;
         Cath <= cath_nxt;
         Dp   <= 1'b1;
      end
   end

endmodule
